// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared game-flow state encoding and the centisecond timebase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    // Shared by this controller and the timer so both agree on one centisecond.
    localparam int CENTI_DIV_DEFAULT = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/game_timer_ctrl_sync_edge.sv
// ============================================================================
// Module      : sync_edge
// Description : Three-flop synchroniser with level (s2) and rising-edge outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign level = r_s2;
    assign rise  = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/game_timer_ctrl.sv
// ============================================================================
// Module      : game_timer_ctrl
// Description : Game-flow FSM producing timer strobes and the post-crash
//               hold/blink window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int CENTI_DIV = CENTI_DIV_DEFAULT,
    parameter int HOLD_CS   = 200,
    parameter int BLINK_CS  = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       collision,
    output logic [1:0] state,
    output logic       run_en,
    output logic       clear_timer,
    output logic       dead_pulse,
    output logic       display_blank,
    output logic       restart_ok
);

    localparam int c_presc_w = (CENTI_DIV > 1) ? $clog2(CENTI_DIV) : 1;
    localparam int c_hold_w  = $clog2(HOLD_CS + 1);
    localparam int c_blink_w = (BLINK_CS > 1) ? $clog2(BLINK_CS) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CENTI_DIV - 1);
    localparam logic [c_hold_w-1:0]  c_hold_max   = c_hold_w'(HOLD_CS);
    localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(HOLD_CS - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_CS - 1);

    logic w_start_rise;
    logic w_pause_rise;
    logic w_coll_level;
    logic w_start_level;
    logic w_pause_level;
    logic w_coll_rise;
    logic w_tick;

    logic [c_presc_w-1:0] r_presc;
    logic [c_hold_w-1:0]  r_hold;
    logic [c_blink_w-1:0] r_blink;
    state_t               r_state;

    sync_edge u_sync_start (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_start),
        .level (w_start_level),
        .rise  (w_start_rise)
    );

    sync_edge u_sync_pause (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_pause),
        .level (w_pause_level),
        .rise  (w_pause_rise)
    );

    sync_edge u_sync_coll (
        .clk   (clk),
        .rst   (rst),
        .din   (collision),
        .level (w_coll_level),
        .rise  (w_coll_rise)
    );

    assign w_tick = (r_presc == c_presc_last);

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            run_en        <= 1'b0;
            clear_timer   <= 1'b0;
            dead_pulse    <= 1'b0;
            display_blank <= 1'b0;
            restart_ok    <= 1'b0;
            r_hold        <= '0;
            r_blink       <= '0;
        end else begin
            clear_timer <= 1'b0;
            dead_pulse  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_state     <= ST_RUN;
                        run_en      <= 1'b1;
                        clear_timer <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Crash wins over a simultaneous pause press.
                    if (w_coll_level) begin
                        r_state       <= ST_OVER;
                        run_en        <= 1'b0;
                        dead_pulse    <= 1'b1;
                        r_hold        <= '0;
                        r_blink       <= '0;
                        display_blank <= 1'b0;
                        restart_ok    <= 1'b0;
                    end else if (w_pause_rise) begin
                        r_state <= ST_PAUSE;
                        run_en  <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_rise || w_start_rise) begin
                        r_state <= ST_RUN;
                        run_en  <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (w_start_rise && restart_ok) begin
                        r_state       <= ST_RUN;
                        run_en        <= 1'b1;
                        clear_timer   <= 1'b1;
                        restart_ok    <= 1'b0;
                        display_blank <= 1'b0;
                    end else if (w_tick) begin
                        r_blink <= (r_blink == c_blink_last) ? '0 : r_blink + 1'b1;
                        // Blink only until the hold expires, then keep the time visible.
                        if (r_hold != c_hold_max) begin
                            r_hold <= r_hold + 1'b1;
                            if (r_hold == c_hold_last) begin
                                restart_ok    <= 1'b1;
                                display_blank <= 1'b0;
                            end else if (r_blink == c_blink_last) begin
                                display_blank <= ~display_blank;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    run_en  <= 1'b0;
                end
            endcase
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
- Game-flow controller that sequences the run/best-time display datapath.
- Converts raw start/pause buttons and the road-collision level into clean timer-control strobes: run enable, clear and a one-cycle dead pulse.
- Runs a post-crash hold/blink window so the final time stays readable before a restart.
- Sits between the board buttons / collision detector and the timer/display block, in the 100 MHz domain.

Parameters:
- CENTI_DIV, 1_000_000, clk cycles per centisecond tick (100 MHz -> 10 ms).
- HOLD_CS, 200, centiseconds in OVER before a restart is accepted (2.00 s).
- BLINK_CS, 25, centiseconds per display_blank half-period while in OVER.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- btn_start  in  1  raw start button, asynchronous level
- btn_pause  in  1  raw pause button, asynchronous level
- collision  in  1  level high while car is off-road, asynchronous
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
- run_en  out  1  high while timer may count
- clear_timer  out  1  one-cycle pulse; zero current time
- dead_pulse  out  1  one-cycle pulse on crash; feeds timer dead input
- display_blank  out  1  high = blank display (blink in OVER)
- restart_ok  out  1  high in OVER once hold has expired

Behaviour:
- Reset is synchronous, active-high, one clock. While rst is sampled high:
  - state=IDLE; run_en, clear_timer, dead_pulse, display_blank and restart_ok are all 0.
  - Prescaler, hold counter, blink counter and all synchroniser flops are cleared.
- Reset mid-operation, in any state, returns to IDLE on the next edge. No dead_pulse is emitted.
- Input conditioning:
  - Each of btn_start, btn_pause and collision passes through a 3-flop chain (s1, s2, s3).
  - A button edge is s2 & ~s3. The collision level is s2.
  - An input high before edge k changes state and registered outputs at edge k+2.
- Prescaler:
  - Free-running 0..CENTI_DIV-1.
  - tick is high for one cycle when count == CENTI_DIV-1, then the count wraps to 0.
- All outputs are registered; no combinational input-to-output paths.
- IDLE:
  - run_en=0, display_blank=0.
  - start edge -> RUN, with clear_timer=1 for exactly that transition cycle.
  - pause edge and collision are ignored.
- RUN:
  - run_en=1.
  - collision level -> OVER, with dead_pulse=1 for one cycle and run_en=0 from the same edge.
  - Otherwise pause edge -> PAUSE.
  - Collision has priority over pause in the same cycle. start edge is ignored.
- PAUSE:
  - run_en=0.
  - pause edge or start edge -> RUN; no clear is issued.
  - collision is ignored: no dead_pulse.
- OVER, on entry:
  - hold counter=0, blink counter=0, display_blank=0, restart_ok=0.
- OVER, on each tick:
  - Hold counter increments and saturates at HOLD_CS.
  - Blink counter increments; at BLINK_CS-1 it wraps to 0 and display_blank toggles.
- OVER, hold expiry:
  - When the hold counter reaches HOLD_CS, restart_ok=1 and display_blank is forced to 0 and stays 0.
- OVER, exit:
  - start edge while restart_ok=1 -> RUN, with clear_timer=1.
  - start edge while restart_ok=0 is discarded, not queued.
  - pause edge and collision are ignored.
- dead_pulse occurs only on a RUN->OVER transition. It never repeats while collision stays high.
- clear_timer and dead_pulse are never high in the same cycle.
- A collision still high when restarting from OVER is handled as follows:
  - The RUN entry cycle is taken normally.
  - If collision is still high on the next edge, RUN->OVER fires again with dead_pulse. This is intended behaviour.
- Counter widths:
  - Prescaler is $clog2(CENTI_DIV) bits.
  - Hold counter is $clog2(HOLD_CS+1) bits.
  - Blink counter is $clog2(BLINK_CS) bits.
  - No counter may overflow.

Decomposition:
- Shared package game_pkg holds:
  - The state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER.
  - The default CENTI_DIV, so the controller and timer share one centisecond definition.
- One sub-module: sync_edge. It is the 3-flop synchroniser with outputs level (s2) and rise (s2 & ~s3). It is instantiated three times.

Test Plan:
All scenarios use CENTI_DIV=4, HOLD_CS=8, BLINK_CS=2.
- Reset, then start pulse of 3 cycles -> state 00 becomes 01 exactly 2 edges after btn_start rises; clear_timer high for 1 cycle; run_en=1.
- RUN, pause pulse, wait 20 cycles, pause pulse -> state 01->10->01; run_en 1->0->1; no clear_timer and no dead_pulse throughout.
- RUN, collision and btn_pause rising in the same cycle -> state 11; dead_pulse exactly 1 cycle; run_en=0; PAUSE never entered.
- OVER, collision held high, start pulsed at tick 3 -> start ignored; display_blank toggles every 8 clk; after 32 clk restart_ok=1 and display_blank=0; no further dead_pulse.
- OVER with restart_ok=1, start pulse -> state 01; clear_timer 1 cycle; with collision released, no dead_pulse.
- rst asserted for 1 cycle during OVER mid-hold -> next edge state 00, all outputs 0; a following start behaves as in scenario 1.
